// File: rtl/forwarding_scoreboard.sv
// Operand forwarding with youngest-first source priority plus a latency scoreboard for
// multi-cycle producers. Defining FWD_SCOREBOARD_STATS_EN adds stall/forward event counters.
module forwarding_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NSRC   = 2,
    parameter int MAXLAT = 7,
    localparam int RW = $clog2(NREGS),
    localparam int LW = $clog2(MAXLAT + 1),
    localparam int SW = $clog2(NSRC + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [NRD*RW-1:0]   rs_dec,
    input  logic                wen_dec,
    input  logic [RW-1:0]       rd_dec,
    input  logic [LW-1:0]       lat_dec,
    input  logic [NSRC-1:0]     src_wen,
    input  logic [NSRC*RW-1:0]  src_rd,
    input  logic [NSRC-1:0]     src_ready,
    input  logic                flush,
    output logic [NRD*SW-1:0]   fwd_sel,
    output logic                stall,
    output logic [NREGS-1:0]    busy_vec,
    output logic [31:0]         stall_count,
    output logic [31:0]         fwd_count
);
    logic [NREGS-1:0] busy_q, busy_d;
    logic [LW-1:0]    cnt_q [NREGS];
    logic [LW-1:0]    cnt_d [NREGS];
    logic [NRD-1:0]   hazard;
    logic             accept;
    logic             sb_write;
    logic [LW-1:0]    lat_sat;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [RW-1:0] rs;
            logic [SW-1:0] sel;
            logic          hit;
            logic          hit_ready;

            assign rs = rs_dec[gi*RW +: RW];

            // Scan oldest to youngest so the youngest matching source is assigned last and wins.
            always_comb begin
                sel       = '0;
                hit       = 1'b0;
                hit_ready = 1'b0;
                for (int k = NSRC - 1; k >= 0; k--) begin
                    if (src_wen[k] && (src_rd[k*RW +: RW] != '0) && (src_rd[k*RW +: RW] == rs)) begin
                        sel       = SW'(k + 1);
                        hit       = 1'b1;
                        hit_ready = src_ready[k];
                    end
                end
            end

            assign fwd_sel[gi*SW +: SW] = sel;
            // A matching source overrides the scoreboard: its readiness alone decides the hazard.
            assign hazard[gi] = (rs != '0) && (hit ? !hit_ready : busy_q[rs]);
        end

        if (MAXLAT < (1 << LW) - 1) begin : g_lat_clamp
            assign lat_sat = (lat_dec > LW'(MAXLAT)) ? LW'(MAXLAT) : lat_dec;
        end else begin : g_lat_pass
            assign lat_sat = lat_dec;
        end
    endgenerate

    assign stall       = issue_valid && (|hazard);
    assign issue_ready = !stall;
    assign accept      = issue_valid && issue_ready;
    assign sb_write    = accept && wen_dec && (rd_dec != '0) && (lat_dec != '0);
    assign busy_vec    = busy_q;

    // Countdown first, then a same-cycle issue write overrides, then flush overrides everything.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        for (int r = 0; r < NREGS; r++) begin
            if (busy_q[r]) begin
                if (cnt_q[r] > LW'(1)) begin
                    cnt_d[r] = cnt_q[r] - LW'(1);
                end else begin
                    busy_d[r] = 1'b0;
                    cnt_d[r]  = '0;
                end
            end
        end
        if (sb_write) begin
            busy_d[rd_dec] = 1'b1;
            cnt_d[rd_dec]  = lat_sat;
        end
        if (flush) begin
            busy_d = '0;
            for (int r = 0; r < NREGS; r++) begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] fwd_count_q, fwd_count_d;
    logic        fwd_hit;

    always_comb begin
        fwd_hit = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (fwd_sel[p*SW +: SW] != '0) begin
                fwd_hit = 1'b1;
            end
        end
        stall_count_d = stall_count_q;
        fwd_count_d   = fwd_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (accept && fwd_hit && (fwd_count_q != '1)) begin
            fwd_count_d = fwd_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;
`else
    assign stall_count = '0;
    assign fwd_count   = '0;
`endif

endmodule
